// File: rtl/stopwatch_pkg.sv
// Shared definitions for the irrigation countdown stopwatch stages
// (units, tens, minutes).
//   SEG_W            : width of a seven-segment drive vector
//   SEG_A..SEG_G     : bit position of each segment inside a seg_t
//   SEG_0..SEG_9     : high-true patterns for the decimal digits
//   SEG_BLANK        : all segments off (high-true)
//   seg_pattern()    : 4-bit code to high-true pattern; codes >= 10 blank
package stopwatch_pkg;

  localparam int SEG_W = 7;
  typedef logic [SEG_W-1:0] seg_t;

  // a=top, b=upper-right, c=lower-right, d=bottom, e=lower-left,
  // f=upper-left, g=middle
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  //                            gfedcba
  localparam seg_t SEG_0     = 7'b0111111;
  localparam seg_t SEG_1     = 7'b0000110;
  localparam seg_t SEG_2     = 7'b1011011;
  localparam seg_t SEG_3     = 7'b1001111;
  localparam seg_t SEG_4     = 7'b1100110;
  localparam seg_t SEG_5     = 7'b1101101;
  localparam seg_t SEG_6     = 7'b1111101;
  localparam seg_t SEG_7     = 7'b0000111;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1101111;
  localparam seg_t SEG_BLANK = 7'b0000000;

  function automatic seg_t seg_pattern(input logic [3:0] code);
    seg_t p;
    case (code)
      4'd0:    p = SEG_0;
      4'd1:    p = SEG_1;
      4'd2:    p = SEG_2;
      4'd3:    p = SEG_3;
      4'd4:    p = SEG_4;
      4'd5:    p = SEG_5;
      4'd6:    p = SEG_6;
      4'd7:    p = SEG_7;
      4'd8:    p = SEG_8;
      4'd9:    p = SEG_9;
      default: p = SEG_BLANK;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/tens_sec_if.sv
// Signal bundle of the tens-of-seconds stage.
//   BORROW_IN      : asynchronous borrow from the units stage (rising edge)
//   P              : synchronous level preset
//   G, A           : zone enables, counting allowed when either is high
//   CLK_OUT        : one-cycle borrow pulse to the minutes stage
//   ZERO           : digit == 0
//   ats..gts       : seven-segment drive for the tens digit
// master = stimulus side, slave = the stage itself.
interface tens_sec_if;
  logic BORROW_IN;
  logic P;
  logic G;
  logic A;
  logic CLK_OUT;
  logic ZERO;
  logic ats, bts, cts, dts, ets, fts, gts;

  modport master (
    output BORROW_IN, P, G, A,
    input  CLK_OUT, ZERO, ats, bts, cts, dts, ets, fts, gts
  );

  modport slave (
    input  BORROW_IN, P, G, A,
    output CLK_OUT, ZERO, ats, bts, cts, dts, ets, fts, gts
  );
endinterface

// File: rtl/tens_sec_bcd_seg7.sv
// bcd_seg7: combinational 4-bit code to seven-segment pattern.
//   code : digit code, values >= 10 produce a blank display
//   seg  : pattern, inverted when ACTIVE_LOW=1 (common-anode display)
module bcd_seg7
  import stopwatch_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] code,
  output seg_t       seg
);

  seg_t pat;

  always_comb begin
    pat = seg_pattern(code);
    seg = ACTIVE_LOW ? ~pat : pat;
  end

endmodule

// File: rtl/tens_sec.sv
// tens_sec: tens-of-seconds digit of the irrigation countdown stopwatch.
// Counts MODULUS-1 down to 0 on each rising edge of the (asynchronous)
// units-stage borrow while G|A, and emits a one-cycle borrow on wrap.
//   CLK_IN, RST_N : system clock, asynchronous active-low reset
//   bus           : tens_sec_if.slave (borrow in/out, preset, enables,
//                   ZERO flag, registered segment drive)
module tens_sec
  import stopwatch_pkg::*;
#(
  parameter int MODULUS        = 6,
  parameter int PRESET         = 5,
  parameter int SYNC_STAGES    = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       CLK_IN,
  input  logic       RST_N,
  tens_sec_if.slave  bus
);

  localparam int DW = $clog2(MODULUS);
  typedef logic [DW-1:0] digit_t;

  // Reset shows "0" in whichever polarity the display uses.
  localparam seg_t SEG_RST = SEG_ACTIVE_LOW ? ~SEG_0 : SEG_0;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  digit_t                 digit_q, digit_d;
  logic                   borrow_q, borrow_d;
  seg_t                   seg_q, seg_d, seg_pat;
  logic                   tick, en;

  // Edge detector samples every cycle, including while P is high, so an
  // edge swallowed by a preset is not replayed when P drops.
  assign tick = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign en   = bus.G | bus.A;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], bus.BORROW_IN};
    prev_d   = sync_q[SYNC_STAGES-1];
    digit_d  = digit_q;
    borrow_d = 1'b0;
    if (bus.P) begin
      digit_d = digit_t'(PRESET);
    end else if (tick && en) begin
      if (digit_q != '0) begin
        digit_d = digit_q - digit_t'(1);
      end else begin
        digit_d  = digit_t'(MODULUS - 1);
        borrow_d = 1'b1;
      end
    end
  end

  bcd_seg7 #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg (
    .code (4'(digit_q)),
    .seg  (seg_pat)
  );

  // Segments trail the digit register by one cycle.
  always_comb seg_d = seg_pat;

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      digit_q  <= '0;
      borrow_q <= 1'b0;
      seg_q    <= SEG_RST;
    end else begin
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      digit_q  <= digit_d;
      borrow_q <= borrow_d;
      seg_q    <= seg_d;
    end
  end

  assign bus.CLK_OUT = borrow_q;
  assign bus.ZERO    = (digit_q == '0);
  assign bus.ats     = seg_q[SEG_A];
  assign bus.bts     = seg_q[SEG_B];
  assign bus.cts     = seg_q[SEG_C];
  assign bus.dts     = seg_q[SEG_D];
  assign bus.ets     = seg_q[SEG_E];
  assign bus.fts     = seg_q[SEG_F];
  assign bus.gts     = seg_q[SEG_G];

endmodule
